// File: rtl/cpu_mem_pkg.sv
// Shared types for the multi-cycle MEM stage: FSM state encoding and
// bit positions inside the two-bit MEMcontrols field.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } memState_e;

  localparam int MEMCTL_RD = 1;
  localparam int MEMCTL_WR = 0;

endpackage

// File: rtl/mem_req_hold.sv
// Capture register for one outstanding memory request (address, direction,
// write data); loads only when the stage accepts a new access.
module mem_req_hold #(
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] addrD,
  input  logic          weD,
  input  logic [DW-1:0] wdataD,
  output logic [AW-1:0] addr,
  output logic          we,
  output logic [DW-1:0] wdata
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr  <= '0;
      we    <= 1'b0;
      wdata <= '0;
    end else if (load) begin
      addr  <= addrD;
      we    <= weD;
      wdata <= wdataD;
    end
  end

endmodule

// File: rtl/cpu_mem_stage_mc.sv
// MEM pipeline stage talking to a multi-cycle data memory over a request /
// response handshake; stalls the pipeline until the access completes or times out.
module cpu_mem_stage_mc
  import cpu_mem_pkg::*;
#(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 64,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_valid,
  input  logic [AW-1:0] alu_out,
  input  logic [DW-1:0] reg_b_data,
  input  logic [1:0]    mem_ctrl,
  input  logic          forward_c,
  input  logic [DW-1:0] wb_fdata,
  output logic          mem_stall,
  output logic [DW-1:0] data_out,
  output logic          done_valid,
  output logic          err,
  output logic          mreq_valid,
  input  logic          mreq_ready,
  output logic          mreq_we,
  output logic [AW-1:0] mreq_addr,
  output logic [DW-1:0] mreq_wdata,
  input  logic          mresp_valid,
  input  logic [DW-1:0] mresp_rdata
);

  // Handshakes: a request transfers on the cycle mreq_valid & mreq_ready are
  // both high, and mreq_* hold steady until then; a response transfers on any
  // cycle mresp_valid is high while in RESP and is ignored in every other state.

  localparam logic [CW-1:0] TLIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  memState_e     state, stateNext;
  logic [CW-1:0] timeCnt;
  logic          access, capture, inFlight, complete, abort;

  assign access   = ex_valid & (mem_ctrl[MEMCTL_RD] | mem_ctrl[MEMCTL_WR]);
  assign capture  = (state == IDLE) & access;
  assign inFlight = (state == REQ) | (state == RESP);
  assign complete = ((state == REQ) & mreq_ready & mreq_we) | ((state == RESP) & mresp_valid);
  // An accepted read that has not yet returned data still counts as unfinished.
  assign abort    = (TIMEOUT > 0) & inFlight & (timeCnt == TLIMIT) & ~complete;

  mem_req_hold #(.DW(DW), .AW(AW)) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (capture),
    .addrD  (alu_out),
    .weD    (mem_ctrl[MEMCTL_WR]),
    .wdataD (forward_c ? wb_fdata : reg_b_data),
    .addr   (mreq_addr),
    .we     (mreq_we),
    .wdata  (mreq_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    mreq_valid = 1'b0;
    mem_stall  = 1'b0;
    done_valid = 1'b0;
    case (state)
      IDLE: begin
        mem_stall = access;
        if (access) stateNext = REQ;
      end
      REQ: begin
        mreq_valid = 1'b1;
        mem_stall  = 1'b1;
        if (abort)           stateNext = DONE;
        else if (mreq_ready) stateNext = mreq_we ? DONE : RESP;
      end
      RESP: begin
        mem_stall = 1'b1;
        if (mresp_valid | abort) stateNext = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        stateNext  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeCnt  <= '0;
      err      <= 1'b0;
      data_out <= '0;
    end else begin
      if (capture)       timeCnt <= '0;
      else if (inFlight) timeCnt <= timeCnt + 1'b1;

      if (capture)    err <= 1'b0;
      else if (abort) err <= 1'b1;

      if ((state == RESP) & mresp_valid) data_out <= mresp_rdata;
      else if (abort & ~mreq_we)         data_out <= '0;
    end
  end

endmodule

// File: doc/cpu_mem_stage_mc.md
Name: cpu_mem_stage_mc

Overview:
Parametrised MEM pipeline stage for the 16-bit CPU and its wider derivatives. It replaces the single-cycle data-memory access with a valid/ready request and response handshake, so the stage works with a multi-cycle data memory or cache. It keeps MEM-to-MEM store-data forwarding. It stalls the pipeline until the access completes and flags a timeout on accesses that never finish. It sits between the EX/MEM and MEM/WB pipeline registers.

Parameters:
DW, 16, data width (load/store data, forwarded data)
AW, 16, address width (ALU result used as address)
TIMEOUT, 64, cycles allowed in REQ+RESP before abort; 0 disables the timeout
CW, 8, width of the timeout counter; must satisfy 2^CW > TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
ex_valid  in  1  EX/MEM register holds a valid instruction
alu_out  in  AW  memory address
reg_b_data  in  DW  store data from the register file
mem_ctrl  in  2  [1]=memRead, [0]=memWrite
forward_c  in  1  select wb_fdata as store data (MEM-to-MEM forwarding)
wb_fdata  in  DW  forwarded write-back data
mem_stall  out  1  freeze the upstream pipeline and the EX/MEM register
data_out  out  DW  load result, registered
done_valid  out  1  one-cycle pulse: access completed this cycle
err  out  1  sticky per-access: this completion was a timeout abort
mreq_valid  out  1  memory request valid
mreq_ready  in  1  memory accepts the request
mreq_we  out  1  1=write, 0=read
mreq_addr  out  AW  request address
mreq_wdata  out  DW  request write data
mresp_valid  in  1  read data valid
mresp_rdata  in  DW  read data

Behaviour:
- Decided interface facts: one clock, clk. Reset rst_n is asynchronous and active-low.
- On reset, regardless of current state: state=IDLE, mreq_valid=0, data_out=0, done_valid=0, err=0, all hold registers=0, counter=0.
- access = ex_valid & (mem_ctrl[1] | mem_ctrl[0]). If both control bits are set, the access is a write and the read is ignored.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - If access: capture addr, we, and wdata = forward_c ? wb_fdata : reg_b_data into hold registers; go to REQ.
  - The forwarding mux is sampled only in this capture cycle.
- REQ:
  - mreq_valid=1; mreq_* driven from the hold registers and stable until accepted.
  - On mreq_ready: a write goes to DONE; a read goes to RESP.
- RESP:
  - Wait for mresp_valid; on it, data_out <= mresp_rdata and go to DONE.
  - mresp_valid in any other state (including the handshake cycle itself) is ignored.
- DONE:
  - done_valid=1; go to IDLE unconditionally.
  - No capture in DONE: the instruction still presented on the inputs is the one just completed.
- mem_stall = (IDLE & access) | REQ | RESP. mem_stall=0 in DONE, so MEM/WB latches data_out at the end of the DONE cycle.
- Minimum latency: load with mreq_ready=1 and mresp_valid the next cycle takes 3 stall cycles plus DONE. Store with mreq_ready=1 takes 2 stall cycles plus DONE.
- Timeout (TIMEOUT>0):
  - Counter clears on entering REQ and increments each cycle in REQ or RESP.
  - When the counter reaches TIMEOUT-1 without completion, go to DONE with err=1.
  - Loads then set data_out=0; mreq_valid drops.
- err is cleared on the next capture.
- data_out changes only on a read completion or a timeout of a read; otherwise it holds.
- Non-memory instructions (access=0) pass with no stall and no memory traffic; data_out holds.

Decomposition:
- Package cpu_mem_pkg holds the state enum (IDLE/REQ/RESP/DONE) and the MEMcontrols bit-index constants (MEMCTL_RD=1, MEMCTL_WR=0).
- One sub-module, mem_req_hold: capture register for addr, we, wdata with a load enable.
- The FSM and timeout counter stay in the top module.

Test Plan:
- Load, addr 0x0010, mreq_ready=1, mresp_valid one cycle after acceptance with 0xBEEF -> mem_stall high 3 cycles; done_valid pulse; data_out=0xBEEF; err=0.
- Store, forward_c=1, wb_fdata=0x1234, reg_b_data=0xFFFF, mreq_ready low 4 cycles -> mreq_wdata=0x1234 held stable throughout; single handshake; done_valid one cycle after acceptance.
- Back-to-back load then non-memory op -> no re-capture in DONE; the following op causes no stall and no mreq_valid.
- TIMEOUT=8, load with mresp_valid never asserted -> DONE after 8 cycles in REQ+RESP; err=1; data_out=0; mem_stall drops.
- Stray mresp_valid=1 with 0xAAAA while IDLE -> ignored; data_out unchanged.
- rst_n pulsed low while in RESP -> mreq_valid, mem_stall, and data_out go to 0 immediately (asynchronously); a new load completes normally after release.
